// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM states
// and the helper that decides which opcodes run on the iterative datapath.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    // MUL and DIV use the bit-serial datapath; a DIV by zero is still
    // diverted to the single-cycle path by the caller.
    function automatic logic is_iter(input logic [3:0] sel);
        return (sel == OP_MUL) || (sel == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file side (master) and
// the sequential ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [3:0]             sel;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   carry;
    logic                   div_zero;

    modport master (
        output start, A, B, sel,
        input  busy, done, result, carry, div_zero
    );

    modport slave (
        input  start, A, B, sel,
        output busy, done, result, carry, div_zero
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Bit-serial multiply/divide engine: shift-add multiplier and restoring
// divider sharing one 2W accumulator and a down-counter. result_o is the
// accumulator value after the current step, so the caller can register it
// on the same edge that last_o is high.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 op_i,      // 0 = multiply, 1 = divide
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   result_o
);
    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    acc_step;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // One iteration: multiply adds B into the upper half when the current
    // multiplier bit is set then shifts right; divide shifts the remainder
    // left and keeps the trial subtraction when it does not borrow.
    always_comb begin
        add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = acc_q[W2-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q) begin
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Accumulator, operand copy and iteration counter.
    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so every flop samples the
        // pre-edge values, regardless of statement order.
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            op_q  <= op_i;
            cnt_q <= CNT_W'(WIDTH);
        end else if (step_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_o   = (cnt_q == CNT_W'(1));
    assign result_o = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: IDLE/EXEC control, single-cycle operations and the
// registered result/flag outputs. MUL and non-zero DIV are delegated to
// the bit-serial engine and take WIDTH+1 cycles; everything else takes one.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int W2 = 2 * WIDTH;

    state_e         state_q, state_d;
    logic           done_q, done_d;
    logic [W2-1:0]  result_q, result_d;
    logic           carry_q, carry_d;
    logic           div_zero_q, div_zero_d;

    logic           md_load, md_step, md_last;
    logic [W2-1:0]  md_result;
    logic [W2-1:0]  sc_result;
    logic           sc_carry, sc_div_zero;
    logic [WIDTH:0] add_sum, sub_diff;
    logic           div_by_zero, go_iter;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (md_load),
        .op_i     (bus.sel == OP_DIV),
        .step_i   (md_step),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .last_o   (md_last),
        .result_o (md_result)
    );

    assign div_by_zero = (bus.sel == OP_DIV) && (bus.B == '0);
    assign go_iter     = is_iter(bus.sel) && !div_by_zero;

    // Single-cycle results straight from the live operands.
    always_comb begin
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_div_zero = 1'b0;
        add_sum     = {1'b0, bus.A} + {1'b0, bus.B};
        sub_diff    = {1'b0, bus.A} - {1'b0, bus.B};
        case (bus.sel)
            OP_ADD: begin
                sc_result[WIDTH-1:0] = add_sum[WIDTH-1:0];
                sc_carry             = add_sum[WIDTH];
            end
            OP_SUB: begin
                sc_result[WIDTH-1:0] = sub_diff[WIDTH-1:0];
                sc_carry             = sub_diff[WIDTH];
            end
            OP_DIV: begin
                // Only reaches the outputs when B is zero.
                sc_result   = {bus.A, {WIDTH{1'b1}}};
                sc_div_zero = 1'b1;
            end
            OP_AND: sc_result[WIDTH-1:0] = bus.A & bus.B;
            OP_OR:  sc_result[WIDTH-1:0] = bus.A | bus.B;
            OP_XOR: sc_result[WIDTH-1:0] = bus.A ^ bus.B;
            OP_NOT: sc_result[WIDTH-1:0] = ~bus.A;
            OP_SHL: begin
                sc_result[WIDTH-1:0] = {bus.A[WIDTH-2:0], 1'b0};
                sc_carry             = bus.A[WIDTH-1];
            end
            OP_SHR: begin
                sc_result[WIDTH-1:0] = {1'b0, bus.A[WIDTH-1:1]};
                sc_carry             = bus.A[0];
            end
            default: ;
        endcase
    end

    // Next state, done pulse and output-register updates.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        done_d     = 1'b0;
        result_d   = result_q;
        carry_d    = carry_q;
        div_zero_d = div_zero_q;
        md_load    = 1'b0;
        md_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (go_iter) begin
                        md_load = 1'b1;
                        state_d = EXEC;
                    end else begin
                        done_d     = 1'b1;
                        result_d   = sc_result;
                        carry_d    = sc_carry;
                        div_zero_d = sc_div_zero;
                    end
                end
            end
            EXEC: begin
                md_step = 1'b1;
                if (md_last) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    result_d   = md_result;
                    carry_d    = 1'b0;
                    div_zero_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q == EXEC);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           c;
        logic           dz;
        logic           it;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W))  bus ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(W))  dut   (.clk(clk), .rst(rst), .bus(bus));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one operation from plain integer arithmetic.
    function automatic exp_t ref_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, mask, r;
        ua   = longint'(a);
        ub   = longint'(b);
        mask = (longint'(1) << W) - 1;
        r    = 0;
        e    = '0;
        case (sel)
            4'd0: begin r = ua + ub; e.c = ((r >> W) & 1) != 0; r = r & mask; end
            4'd1: begin r = (ua - ub) & mask; e.c = (ua < ub); end
            4'd2: begin r = ua * ub; e.it = 1'b1; end
            4'd3: begin
                if (ub == 0) begin
                    r = (ua << W) | mask; e.dz = 1'b1;
                end else begin
                    r = ((ua % ub) << W) | (ua / ub); e.it = 1'b1;
                end
            end
            4'd4: r = ua & ub;
            4'd5: r = ua | ub;
            4'd6: r = ua ^ ub;
            4'd7: r = (~ua) & mask;
            4'd8: begin r = (ua << 1) & mask; e.c = ((ua >> (W - 1)) & 1) != 0; end
            4'd9: begin r = ua >> 1; e.c = (ua & 1) != 0; end
            default: r = 0;
        endcase
        e.res = r[2*W-1:0];
        return e;
    endfunction

    // Behavioural model: an accepted op finishes after 1 cycle, or after
    // W+1 cycles for MUL / non-zero DIV; requests while busy are dropped.
    exp_t           cur;
    logic           m_busy = 1'b0, m_done = 1'b0, m_carry = 1'b0, m_dz = 1'b0;
    logic [2*W-1:0] m_result = '0;
    int             m_left = 0;
    exp_t           pend = '0;

    always_comb cur = ref_op(bus.sel, bus.A, bus.B);

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0;
            m_carry <= 1'b0; m_dz <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_result <= pend.res; m_carry <= pend.c; m_dz <= pend.dz;
                end
            end else if (bus.start) begin
                if (cur.it) begin
                    m_left <= W; m_busy <= 1'b1; pend <= cur;
                end else begin
                    m_done <= 1'b1;
                    m_result <= cur.res; m_carry <= cur.c; m_dz <= cur.dz;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        check("cmp busy",     bus.busy,     m_busy);
        check("cmp done",     bus.done,     m_done);
        check("cmp result",   bus.result,   m_result);
        check("cmp carry",    bus.carry,    m_carry);
        check("cmp div_zero", bus.div_zero, m_dz);
    end

    // Issue one op, wait for done (bounded) and pin the outcome to literals.
    task automatic run_op(input string name, input logic [3:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] er, input logic ec,
                          input logic edz, input int elat);
        int lat, bcnt;
        @(negedge clk);
        bus.start = 1'b1; bus.sel = sel; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 1;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
        end
        check({name, " latency"},     lat,          elat);
        check({name, " busy cycles"}, bcnt,         (elat > 1) ? elat - 1 : 0);
        check({name, " result"},      bus.result,   er);
        check({name, " carry"},       bus.carry,    ec);
        check({name, " div_zero"},    bus.div_zero, edz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, dones;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sel = '0;
        bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.sel = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy",     bus.busy,     1'b0);
        check("reset done",     bus.done,     1'b0);
        check("reset result",   bus.result,   16'h0000);
        check("reset carry",    bus.carry,    1'b0);
        check("reset div_zero", bus.div_zero, 1'b0);
        rst = 1'b0;

        run_op("add 10+5",    4'b0000, 8'd10,  8'd5,   16'h000F, 1'b0, 1'b0, 1);
        run_op("add 200+100", 4'b0000, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1);
        run_op("sub 5-10",    4'b0001, 8'd5,   8'd10,  16'h00FB, 1'b1, 1'b0, 1);
        run_op("shl 0x81",    4'b1000, 8'h81,  8'd0,   16'h0002, 1'b1, 1'b0, 1);
        run_op("shr 10",      4'b1001, 8'd10,  8'd0,   16'h0005, 1'b0, 1'b0, 1);
        run_op("xor",         4'b0110, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1);
        run_op("not",         4'b0111, 8'h0F,  8'd0,   16'h00F0, 1'b0, 1'b0, 1);
        run_op("opcode 1100", 4'b1100, 8'hAA,  8'h55,  16'h0000, 1'b0, 1'b0, 1);
        run_op("mul 200*100", 4'b0010, 8'd200, 8'd100, 16'h4E20, 1'b0, 1'b0, 9);
        run_op("div 10/5",    4'b0011, 8'd10,  8'd5,   16'h0002, 1'b0, 1'b0, 9);
        run_op("div 200/7",   4'b0011, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 9);
        run_op("div 10/0",    4'b0011, 8'd10,  8'd0,   16'h0AFF, 1'b0, 1'b1, 1);

        // MUL in flight: a start at cycle 3 is ignored, result holds.
        @(negedge clk);
        bus.start = 1'b1; bus.sel = 4'b0010; bus.A = 8'd200; bus.B = 8'd100;
        @(negedge clk); bus.start = 1'b0; k = 1;
        @(negedge clk); k++;
        @(negedge clk); k++;
        bus.start = 1'b1; bus.sel = 4'b0000; bus.A = 8'd1; bus.B = 8'd1;
        @(negedge clk); k++;
        bus.start = 1'b0;
        check("inflight result held", bus.result, 16'h0AFF);
        check("inflight no done",     bus.done,   1'b0);
        while (!bus.done && k < 30) begin
            @(negedge clk); k++;
        end
        check("inflight mul latency", k,          9);
        check("inflight mul result",  bus.result, 16'h4E20);
        // Start in the done cycle is accepted with no bubble.
        bus.start = 1'b1; bus.sel = 4'b0000; bus.A = 8'd10; bus.B = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("back-to-back done",   bus.done,   1'b1);
        check("back-to-back result", bus.result, 16'h000F);

        // Reset at cycle 4 of a DIV aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.sel = 4'b0011; bus.A = 8'd10; bus.B = 8'd5;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",     bus.busy,     1'b0);
        check("abort result",   bus.result,   16'h0000);
        check("abort carry",    bus.carry,    1'b0);
        check("abort div_zero", bus.div_zero, 1'b0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort no done", dones, 0);
        run_op("add 1+1 after abort", 4'b0000, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1);

        // WIDTH=16 instance: full-range multiply.
        @(negedge clk);
        bus16.start = 1'b1; bus16.sel = 4'b0010; bus16.A = 16'hFFFF; bus16.B = 16'hFFFF;
        @(negedge clk); bus16.start = 1'b0; k = 1;
        while (!bus16.done && k < 40) begin
            @(negedge clk); k++;
        end
        check("w16 mul latency", k,            17);
        check("w16 mul result",  bus16.result, 32'hFFFE0001);

        // Randomized traffic, including requests while busy and rare resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            bus.start = 1'($urandom_range(0, 1));
            bus.sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 3)) : 4'($urandom_range(0, 15));
            bus.A     = W'($urandom);
            bus.B     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 8-bit combinational ALU. It keeps the same 4-bit opcode set and adds a start/busy/done handshake, registered outputs and a `div_zero` flag. Multiply and divide run iteratively, one bit per clock: shift-add multiply and restoring divide. This removes the combinational `*` and `/` arrays. The block sits between the datapath register file and the writeback mux.

## Interface
- `WIDTH`, default 8: operand width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `A`, `B`  in  WIDTH each  operands; captured on the accepted `start` edge.
- `sel`  in  4  opcode; captured on the accepted `start` edge.
- `busy`  out  1  high while an iterative op is running.
- `done`  out  1  one-cycle pulse; `result`, `carry` and `div_zero` are valid from this cycle.
- `result`  out  2*WIDTH  registered result.
- `carry`  out  1  carry or borrow flag.
- `div_zero`  out  1  the last divide had B=0.

## Operation
- Opcodes and results (all results zero-extended to 2*WIDTH):
  - 0000 ADD: A+B; `carry` = carry-out.
  - 0001 SUB: A−B mod 2^W; `carry` = borrow (A<B).
  - 0010 MUL: full 2W-bit product; `carry`=0.
  - 0011 DIV: {remainder, quotient}, remainder in the upper W bits; `carry`=0.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A: bitwise ops; `carry`=0.
  - 1000 SHL: A<<1; `carry`=A[W-1].
  - 1001 SHR: A>>1; `carry`=A[0].
  - 1010–1111: `result`=0, `carry`=0; completes like a single-cycle op.
- FSM has two states, IDLE and EXEC.
  - IDLE + `start`, single-cycle opcode: compute, register outputs, pulse `done`; stay in IDLE.
  - IDLE + `start`, MUL, or DIV with B≠0: capture operands; counter=WIDTH; go to EXEC; `busy`=1.
  - EXEC: one iteration per edge; counter decrements. On the edge where counter reaches 0: write the result, pulse `done`, clear `busy`, return to IDLE.
  - DIV with B=0 is handled as a single-cycle op: `result`={A, all-ones}, `div_zero`=1.
- `div_zero` updates on every `done`. It is 1 only for a DIV with B=0.
- In EXEC, `start`, `A`, `B` and `sel` are ignored. Internal copies are used.
- `result`, `carry` and `div_zero` hold their values until the next `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `carry`=0, `div_zero`=0; state=IDLE.
- Single-cycle ops: `start` sampled at edge N; `done`=1 and outputs valid after edge N (latency 1).
- MUL/DIV: `start` sampled at edge N; `busy`=1 after edges N..N+WIDTH−1; `done`=1 after edge N+WIDTH (latency WIDTH+1).
- Back-to-back: `start` in the same cycle as `done` is accepted, giving zero bubble.
- `rst` during EXEC aborts the op: all outputs go to reset values and no `done` is issued.
- `rst` and `start` in the same cycle: reset wins.

## Structure
- Package `alu_pkg` contains:
  - opcode localparams `OP_ADD` … `OP_SHR`;
  - state enum `IDLE`/`EXEC`;
  - an `is_iter(sel)` function.
- Sub-module `alu_muldiv_iter` holds the iterative datapath:
  - shift-add multiplier and restoring divider;
  - shared 2W accumulator and the iteration counter;
  - interface: `load`, `op`, `step` in; `last` out.
- The top level holds the FSM, the single-cycle ops and the output registers.

## Test plan
WIDTH=8 unless stated.
- ADD A=10, B=5 → `done` 1 cycle after `start`; `result`=0x000F, `carry`=0. ADD A=200, B=100 → `result`=0x002C, `carry`=1.
- SUB A=5, B=10 → `result`=0x00FB, `carry`=1. SHL A=0x81 → `result`=0x0002, `carry`=1. SHR A=10 → `result`=0x0005, `carry`=0.
- MUL A=200, B=100 → `busy` for 8 cycles, `done` 9 cycles after `start`; `result`=0x4E20. With WIDTH=16, 0xFFFF×0xFFFF → `result`=0xFFFE0001 after 17 cycles.
- DIV A=10, B=5 → `result`=0x0002, `div_zero`=0. DIV A=10, B=0 → `done` after 1 cycle, `result`=0x0AFF, `div_zero`=1.
- MUL in flight: `start` with `sel`=ADD at cycle 3 is ignored and `result` stays at its old value until the MUL's `done`. Then a new `start` issued in the `done` cycle is accepted.
- `rst` at cycle 4 of a DIV → all outputs 0, no `done` pulse. The next ADD 1+1 → `result`=0x0002.
